// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data-memory access unit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Byte-enable pattern for an access of the given size at the given low address bits.
  function automatic logic [3:0] beFor(input logic [1:0] size, input logic [1:0] addrLo);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << addrLo;
      SZ_H:    be = 4'b0011 << {addrLo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane the access could land in.
  function automatic logic [31:0] wdataFor(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      SZ_B:    w = {4{data[7:0]}};
      SZ_H:    w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Natural alignment: bytes always, halves on even addresses, words on multiples of four.
  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~addrLo[0];
      default: ok = (addrLo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Lane selection and extension; word loads return the raw word.
  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    lane8   = shifted[7:0];
    lane16  = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    result = uns ? {24'h000000, lane8} : {{24{lane8[7]}}, lane8};
      SZ_H:    result = uns ? {16'h0000, lane16} : {{16{lane16[15]}}, lane16};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage access unit: passes non-memory ops straight to MEM/WB and runs loads/stores
// over a req/ack bus, holding the pipeline until the access completes or times out.
// Handshake: a bus access is a single request held (dm_req=1, address/data/enables stable)
// from the first BUSY cycle until the rising edge on which dm_ack=1 is sampled; dm_ack
// outside BUSY carries no meaning and is ignored.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [4:0]  ex_gpr_des,
  input  logic        ex_reg_w,
  input  logic        ex_mem_to_r,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall_out,
  output logic        wb_write,
  output logic [4:0]  wb_gpr_des,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_out,
  output logic        wb_reg_w,
  output logic        wb_mem_to_r,
  output logic        misalign_exc,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACK_TIMEOUT - 1);

  state_t      state, nextState;
  logic [CNT_W-1:0] cnt;
  logic        errFlag;
  logic [31:0] hAddr;
  logic        hWe;
  logic        hMemRead;
  logic [3:0]  hBe;
  logic [31:0] hWdata;
  logic [1:0]  hSize;
  logic        hUns;
  logic [4:0]  hGpr;
  logic        hRegW;
  logic        hMemToR;
  logic [31:0] hMemOut;
  logic [31:0] loadData;
  logic        memOp;
  logic        aligned;
  logic        startAccess;
  logic        timedOut;

  assign memOp       = ex_valid & (ex_mem_read | ex_mem_write);
  assign aligned     = isAligned(ex_size, ex_alu_out[1:0]);
  assign startAccess = (state == IDLE) & memOp & aligned;
  assign timedOut    = (state == BUSY) & ~dm_ack & (cnt == LAST_CNT);
  assign dbg_state   = state;

  load_extract uExtract (
    .rdata  (dm_rdata),
    .addr   (hAddr[1:0]),
    .size   (hSize),
    .uns    (hUns),
    .result (loadData)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Holding registers, timeout counter and error flag for the access in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      errFlag  <= 1'b0;
      hAddr    <= '0;
      hWe      <= 1'b0;
      hMemRead <= 1'b0;
      hBe      <= '0;
      hWdata   <= '0;
      hSize    <= '0;
      hUns     <= 1'b0;
      hGpr     <= '0;
      hRegW    <= 1'b0;
      hMemToR  <= 1'b0;
      hMemOut  <= '0;
    end else if (startAccess) begin
      cnt      <= '0;
      errFlag  <= 1'b0;
      hAddr    <= ex_alu_out;
      hWe      <= ex_mem_write;
      hMemRead <= ex_mem_read;
      hBe      <= beFor(ex_size, ex_alu_out[1:0]);
      hWdata   <= wdataFor(ex_size, ex_store_data);
      hSize    <= ex_size;
      hUns     <= ex_unsigned;
      hGpr     <= ex_gpr_des;
      hRegW    <= ex_reg_w;
      hMemToR  <= ex_mem_to_r;
      hMemOut  <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (dm_ack && hMemRead) hMemOut <= loadData;
      if (timedOut)           errFlag <= 1'b1;
    end
  end

  // Next state plus every bus, stall and MEM/WB output.
  always_comb begin
    nextState    = state;
    stall_out    = 1'b0;
    wb_write     = 1'b0;
    wb_gpr_des   = ex_gpr_des;
    wb_alu_out   = ex_alu_out;
    wb_mem_out   = '0;
    wb_reg_w     = ex_reg_w;
    wb_mem_to_r  = ex_mem_to_r;
    misalign_exc = 1'b0;
    bus_err      = 1'b0;
    dm_req       = 1'b0;
    dm_we        = 1'b0;
    dm_addr      = {hAddr[31:2], 2'b00};
    dm_be        = hBe;
    dm_wdata     = hWdata;
    case (state)
      IDLE: begin
        if (memOp && !aligned) begin
          // Misaligned access retires as a bubble with no bus traffic.
          misalign_exc = 1'b1;
          wb_write     = 1'b1;
          wb_reg_w     = 1'b0;
        end else if (memOp) begin
          stall_out = 1'b1;
          nextState = BUSY;
        end else begin
          wb_write = ex_valid;
        end
      end
      BUSY: begin
        dm_req    = 1'b1;
        dm_we     = hWe;
        stall_out = 1'b1;
        if (dm_ack || timedOut) nextState = RESP;
      end
      RESP: begin
        wb_write    = 1'b1;
        wb_gpr_des  = hGpr;
        wb_alu_out  = hAddr;
        wb_mem_out  = hMemOut;
        wb_reg_w    = hRegW & ~errFlag;
        wb_mem_to_r = hMemToR;
        bus_err     = errFlag;
        nextState   = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage and its load_extract sub-module.
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk, rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_unsigned, ex_reg_w, ex_mem_to_r;
  logic [31:0] ex_alu_out, ex_store_data;
  logic [1:0]  ex_size;
  logic [4:0]  ex_gpr_des;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        stall_out, wb_write, wb_reg_w, wb_mem_to_r, misalign_exc, bus_err;
  logic [4:0]  wb_gpr_des;
  logic [31:0] wb_alu_out, wb_mem_out;
  logic [1:0]  dbg_state;

  logic [31:0] le_rdata, le_result;
  logic [1:0]  le_addr, le_size;
  logic        le_uns;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_gpr_des(ex_gpr_des), .ex_reg_w(ex_reg_w),
    .ex_mem_to_r(ex_mem_to_r),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_out(stall_out), .wb_write(wb_write), .wb_gpr_des(wb_gpr_des),
    .wb_alu_out(wb_alu_out), .wb_mem_out(wb_mem_out), .wb_reg_w(wb_reg_w),
    .wb_mem_to_r(wb_mem_to_r), .misalign_exc(misalign_exc), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  load_extract u_le (
    .rdata(le_rdata), .addr(le_addr), .size(le_size), .uns(le_uns), .result(le_result)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic set_nop();
    ex_valid = 0; ex_alu_out = 0; ex_store_data = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_size = SZ_W; ex_unsigned = 0; ex_gpr_des = 0; ex_reg_w = 0; ex_mem_to_r = 0;
    dm_ack = 0; dm_rdata = 0;
  endtask

  task automatic set_entry(input logic [31:0] a, input logic [31:0] sd, input logic rd,
                           input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [4:0] gpr, input logic regw, input logic m2r);
    ex_valid = 1; ex_alu_out = a; ex_store_data = sd; ex_mem_read = rd; ex_mem_write = wr;
    ex_size = sz; ex_unsigned = uns; ex_gpr_des = gpr; ex_reg_w = regw; ex_mem_to_r = m2r;
  endtask

  task automatic test_reset();
    set_nop();
    rst = 1'b1;
    #1 rst = 1'b0;
    set_entry(32'h0000DEAD, 0, 0, 0, SZ_W, 0, 5'd3, 1, 0);
    #1;
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_dm_req: got %b want 0", dm_req); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    n_checks++; if (wb_write !== 1'b1) begin n_fail++; $display("FAIL reset_passthru_write: got %b want 1", wb_write); end
    n_checks++; if (wb_alu_out !== 32'h0000DEAD) begin n_fail++; $display("FAIL reset_passthru_alu: got %h want 0000dead", wb_alu_out); end
    n_checks++; if (wb_mem_out !== 32'h0) begin n_fail++; $display("FAIL reset_mem_out: got %h want 0", wb_mem_out); end
    n_checks++; if (wb_gpr_des !== 5'd3) begin n_fail++; $display("FAIL reset_gpr: got %0d want 3", wb_gpr_des); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_nop();
  endtask

  task automatic test_load_extract();
    logic [31:0] rd [7] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                            32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
    logic [1:0]  ad [7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0};
    logic [1:0]  sz [7] = '{SZ_B, SZ_B, SZ_H, SZ_W, SZ_H, SZ_B, SZ_H};
    logic        un [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] ex [7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h80FF7F01,
                            32'h000080FF, 32'h0000007F, 32'h00007F01};
    for (int i = 0; i < 7; i++) begin
      le_rdata = rd[i]; le_addr = ad[i]; le_size = sz[i]; le_uns = un[i];
      #1;
      n_checks++;
      if (le_result !== ex[i]) begin
        n_fail++; $display("FAIL load_extract[%0d]: got %h want %h", i, le_result, ex[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    int stalls = 0;
    @(negedge clk);
    set_entry(32'h00001003, 32'h000000AB, 0, 1, SZ_B, 0, 5'd0, 0, 0);
    #2;
    if (stall_out) stalls++;
    n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL store_idle_req: got %b want 0", dm_req); end
    @(negedge clk); #2;
    if (stall_out) stalls++;
    n_checks++; if (dm_req !== 1'b1 || dm_we !== 1'b1) begin n_fail++; $display("FAIL store_req_we: got %b%b want 11", dm_req, dm_we); end
    n_checks++; if (dm_addr !== 32'h00001000) begin n_fail++; $display("FAIL store_addr: got %h want 00001000", dm_addr); end
    n_checks++; if (dm_be !== 4'b1000) begin n_fail++; $display("FAIL store_be: got %b want 1000", dm_be); end
    n_checks++; if (dm_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL store_wdata: got %h want abababab", dm_wdata); end
    @(negedge clk);
    dm_ack = 1;
    #2;
    if (stall_out) stalls++;
    @(negedge clk);
    dm_ack = 0;
    #2;
    n_checks++; if (stalls != 3) begin n_fail++; $display("FAIL store_stall_cycles: got %0d want 3", stalls); end
    n_checks++; if (wb_write !== 1'b1 || stall_out !== 1'b0) begin n_fail++; $display("FAIL store_resp: got write=%b stall=%b want 1 0", wb_write, stall_out); end
    n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL store_resp_req: got %b want 0", dm_req); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_loads();
    logic [31:0] ad [4] = '{32'h00001003, 32'h00001003, 32'h00001002, 32'h00001000};
    logic [1:0]  sz [4] = '{SZ_B, SZ_B, SZ_H, SZ_W};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h80FF7F01};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_entry(ad[i], 0, 1, 0, sz[i], un[i], 5'(10 + i), 1, 1);
      #2;
      n_checks++; if (wb_write !== 1'b0 || stall_out !== 1'b1) begin n_fail++; $display("FAIL load_idle[%0d]: got write=%b stall=%b want 0 1", i, wb_write, stall_out); end
      @(negedge clk);
      dm_ack = 1; dm_rdata = 32'h80FF7F01;
      #2;
      n_checks++; if (dm_req !== 1'b1 || dm_we !== 1'b0) begin n_fail++; $display("FAIL load_busy[%0d]: got req=%b we=%b want 1 0", i, dm_req, dm_we); end
      @(negedge clk);
      dm_ack = 0; dm_rdata = 32'h0;
      #2;
      n_checks++; if (wb_mem_out !== ex[i]) begin n_fail++; $display("FAIL load_data[%0d]: got %h want %h", i, wb_mem_out, ex[i]); end
      n_checks++; if (wb_write !== 1'b1 || wb_reg_w !== 1'b1 || wb_gpr_des !== 5'(10 + i)) begin
        n_fail++; $display("FAIL load_resp[%0d]: got write=%b regw=%b gpr=%0d want 1 1 %0d", i, wb_write, wb_reg_w, wb_gpr_des, 10 + i);
      end
      @(negedge clk);
      set_nop();
    end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    set_entry(32'h00002001, 0, 1, 0, SZ_H, 0, 5'd7, 1, 1);
    #2;
    n_checks++; if (misalign_exc !== 1'b1) begin n_fail++; $display("FAIL misalign_exc: got %b want 1", misalign_exc); end
    n_checks++; if (wb_write !== 1'b1 || wb_reg_w !== 1'b0) begin n_fail++; $display("FAIL misalign_wb: got write=%b regw=%b want 1 0", wb_write, wb_reg_w); end
    n_checks++; if (dm_req !== 1'b0 || stall_out !== 1'b0) begin n_fail++; $display("FAIL misalign_bus: got req=%b stall=%b want 0 0", dm_req, stall_out); end
    @(negedge clk);
    set_nop();
    #2;
    n_checks++; if (misalign_exc !== 1'b0 || dm_req !== 1'b0) begin n_fail++; $display("FAIL misalign_after: got exc=%b req=%b want 0 0", misalign_exc, dm_req); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    @(negedge clk);
    set_entry(32'h00003000, 0, 1, 0, SZ_W, 0, 5'd9, 1, 1);
    #2;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #2;
      if (dm_req) req_cycles++;
      else break;
    end
    n_checks++; if (req_cycles != 16) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want 16", req_cycles); end
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout_bus_err: got %b want 1", bus_err); end
    n_checks++; if (wb_write !== 1'b1 || wb_reg_w !== 1'b0) begin n_fail++; $display("FAIL timeout_wb: got write=%b regw=%b want 1 0", wb_write, wb_reg_w); end
    @(negedge clk);
    set_nop();
    #2;
    n_checks++; if (dbg_state !== 2'd0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_after: got state=%0d err=%b want 0 0", dbg_state, bus_err); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs = '0;
    @(negedge clk);
    set_entry(32'h00001234, 0, 0, 0, SZ_W, 0, 5'd1, 1, 0);
    #2; obs = {obs[5:0], wb_write};
    n_checks++; if (wb_alu_out !== 32'h00001234 || wb_mem_out !== 32'h0) begin n_fail++; $display("FAIL b2b_alu: got alu=%h mem=%h want 00001234 0", wb_alu_out, wb_mem_out); end
    @(negedge clk);
    set_entry(32'h00000100, 0, 1, 0, SZ_W, 0, 5'd2, 1, 1);
    #2; obs = {obs[5:0], wb_write};
    @(negedge clk);
    dm_ack = 1; dm_rdata = 32'h11112222;
    #2; obs = {obs[5:0], wb_write};
    @(negedge clk);
    dm_ack = 0;
    #2; obs = {obs[5:0], wb_write};
    n_checks++; if (wb_mem_out !== 32'h11112222) begin n_fail++; $display("FAIL b2b_load1: got %h want 11112222", wb_mem_out); end
    @(negedge clk);
    set_entry(32'h00000104, 0, 1, 0, SZ_W, 0, 5'd3, 1, 1);
    #2; obs = {obs[5:0], wb_write};
    @(negedge clk);
    dm_ack = 1; dm_rdata = 32'h33334444;
    #2; obs = {obs[5:0], wb_write};
    @(negedge clk);
    dm_ack = 0;
    #2; obs = {obs[5:0], wb_write};
    n_checks++; if (wb_mem_out !== 32'h33334444) begin n_fail++; $display("FAIL b2b_load2: got %h want 33334444", wb_mem_out); end
    n_checks++; if (obs !== 7'b1001001) begin n_fail++; $display("FAIL b2b_write_pattern: got %b want 1001001", obs); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    set_entry(32'h00004000, 0, 1, 0, SZ_W, 0, 5'd4, 1, 1);
    @(negedge clk);
    @(negedge clk);
    #2;
    n_checks++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL rstbusy_req_before: got %b want 1", dm_req); end
    #1;
    rst = 1'b0;
    set_nop();
    #1;
    n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL rstbusy_req: got %b want 0", dm_req); end
    n_checks++; if (dbg_state !== 2'd0 || stall_out !== 1'b0) begin n_fail++; $display("FAIL rstbusy_state: got state=%0d stall=%b want 0 0", dbg_state, stall_out); end
    @(negedge clk);
    rst = 1'b1;
    dm_ack = 1; dm_rdata = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #2;
      n_checks++;
      if (wb_write !== 1'b0 || dm_req !== 1'b0) begin
        n_fail++; $display("FAIL rstbusy_late_ack[%0d]: got write=%b req=%b want 0 0", k, wb_write, dm_req);
      end
    end
    dm_ack = 0;
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_load_extract();
    test_byte_store();
    test_loads();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data-memory access unit between the EX/MEM register and the MEM/WB register. It takes one EX/MEM entry per accepted cycle and performs loads and stores over a req/ack data-memory bus. Loads get byte/halfword lane extraction and extension. The unit stalls upstream while a bus access is pending and drives the MEM/WB Write enable plus all MEM/WB data inputs.

Parameters:
ACK_TIMEOUT, 16, cycles waited in BUSY for dm_ack before a bus error is declared (min 1)
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  EX/MEM entry valid
ex_alu_out  in  32  ALU result / effective address
ex_store_data  in  32  store source register value
ex_mem_read  in  1  load
ex_mem_write  in  1  store (never both with mem_read)
ex_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
ex_unsigned  in  1  zero-extend load when 1, sign-extend when 0
ex_gpr_des  in  5  destination register
ex_reg_w  in  1  register write enable
ex_mem_to_r  in  1  writeback selects memory data
dm_req  out  1  bus request
dm_we  out  1  bus write
dm_addr  out  32  word-aligned address {ex_alu_out[31:2],2'b00}
dm_be  out  4  byte enables
dm_wdata  out  32  lane-replicated store data
dm_ack  in  1  bus completion, sampled on clk rise
dm_rdata  in  32  read word, valid with dm_ack
stall_out  out  1  hold PC/IF/ID/EX/MEM registers
wb_write  out  1  MEM/WB Write enable
wb_gpr_des  out  5  to MEM/WB
wb_alu_out  out  32  to MEM/WB
wb_mem_out  out  32  to MEM/WB, extended load data
wb_reg_w  out  1  to MEM/WB
wb_mem_to_r  out  1  to MEM/WB
misalign_exc  out  1  one-cycle pulse, misaligned access
bus_err  out  1  one-cycle pulse, ack timeout

Behaviour:
- Byte lane k is data[8k+7:8k] (little-endian). Aligned means: any byte; half with addr[0]=0; word with addr[1:0]=0.
- mem_op = ex_valid & (ex_mem_read | ex_mem_write).
- FSM states: IDLE, BUSY, RESP.
- IDLE, no mem_op:
  - Combinational pass-through: wb_write=ex_valid, wb_* = ex_*, wb_mem_out=0.
  - stall_out=0.
- IDLE, mem_op misaligned:
  - No bus access; misalign_exc=1, wb_write=1, wb_reg_w=0, stall_out=0. The instruction is retired as a bubble.
- IDLE, mem_op aligned:
  - stall_out=1; capture entry, dm_be and dm_wdata into holding registers; go to BUSY.
- BUSY:
  - dm_req=1; dm_we, dm_addr, dm_be, dm_wdata stable from the holding registers; stall_out=1; wb_write=0.
  - Counter increments every cycle.
  - dm_ack=1 → capture the extended dm_rdata (loads) and go to RESP.
  - Counter reaches ACK_TIMEOUT-1 without ack → set error flag, go to RESP.
- RESP (exactly one cycle):
  - wb_write=1; wb_* from the holding registers; stall_out=0, so EX/MEM advances.
  - If the error flag is set: bus_err=1 and wb_reg_w=0.
  - Next state is IDLE. A new request is evaluated only in the following cycle, so back-to-back memory ops cost 3 cycles minimum.
- Latency: ack in the first BUSY cycle gives a 3-cycle memory op; non-memory ops take 1 cycle.
- dm_be: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
- dm_wdata: byte replicated ×4, half replicated ×2, word as-is.
- Load extract: select the lane(s) by address, then sign- or zero-extend to 32 bits per ex_unsigned. Word loads ignore ex_unsigned.
- dm_req=0 and dm_we=0 outside BUSY. dm_ack outside BUSY is ignored.
- Reset (rst=0, async):
  - state=IDLE; counter, error flag and all holding registers cleared.
  - Outputs fall to IDLE pass-through values; dm_req=0 immediately.
  - A transaction in flight is abandoned; a late ack after release is ignored.
- The counter clears on every entry to BUSY. Counter logic must not wrap before timeout, which the CNT_W constraint guarantees.

Decomposition:
- Shared package mem_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and size codes (SZ_B, SZ_H, SZ_W).
- Sub-module load_extract (combinational: rdata, addr[1:0], size, unsigned → 32-bit result). The test plan exercises it directly.

Test Plan:
- Reset during BUSY: drop rst in the 2nd BUSY cycle → dm_req=0 at once, state IDLE, stall_out=0; ack held high after release produces no wb_write beyond pass-through.
- Byte store: addr 0x1003, data 0x000000AB, ack after 2 cycles → dm_addr=0x1000, dm_be=1000, dm_wdata=0xABABABAB, stall_out=1 for 3 cycles, then one RESP cycle with wb_write=1.
- Loads from rdata=0x80FF7F01:
  - signed byte @0x..3 → 0xFFFFFF80; unsigned byte @0x..3 → 0x00000080.
  - signed half @0x..2 → 0xFFFF80FF; word → 0x80FF7F01.
- Misalign: half load @0x2001 → misalign_exc=1 for 1 cycle, dm_req never rises, wb_write=1, wb_reg_w=0.
- Timeout: no ack, ACK_TIMEOUT=16 → dm_req high exactly 16 cycles, then bus_err=1, wb_reg_w=0 in RESP, then IDLE.
- Back-to-back: ALU op then two loads each acked in the 1st BUSY cycle → wb_write pattern 1,0,0,1,0,0,1; the ALU result passes through in cycle 0 with wb_mem_out=0.
